sevseg_ctrl: RTL and testbench
==============================

Name: sevseg_ctrl

Overview:
- Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment digits from one register file.
- Each digit shows either a hex-decoded nibble or raw segment bits.
- Supports global blanking and per-digit blinking from an internal programmable blink timer.
- Sits on the system interconnect in place of one-PIO-per-digit display ports.

Parameters:
- NUM_DIGITS, 4, number of digits driven; legal range 1..8.
- ACTIVE_LOW, 1, 1 = segment lit when its output bit is 0; 0 = lit when 1.
- BLINK_W, 26, width of the blink period register and the blink down-counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  register word offset.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data.
- readdata  output  32  combinational readback of the addressed register.
- out_port  output  7*NUM_DIGITS  segments; digit d occupies bits [7d+6:7d], bit 0 = seg a … bit 6 = seg g.

Behaviour:
- Register map (unused bits read 0, writes to them ignored):
  - 0 DATA: nibble d at bits [4d+3:4d] for d < NUM_DIGITS.
  - 1 CTRL: bit0 RAW (0 = hex decode, 1 = raw); bit1 BLANK; bit2 BLINK_EN.
  - 2 BLINK_MASK: bits [NUM_DIGITS-1:0].
  - 3 BLINK_PERIOD: bits [BLINK_W-1:0].
  - 4 RAW_LO: digits 0-3, 7 bits each at bits [8k+6:8k].
  - 5 RAW_HI: digits 4-7, same layout.
- RAW fields for digits ≥ NUM_DIGITS are not stored. Offsets 6 and 7 read 0 and ignore writes.
- Reset state: all registers 0. Blink counter 0, blink phase 0. out_port = all segments off (all ones if ACTIVE_LOW=1, else all zeros).
- Register update: write data is captured at the rising edge where the write occurs.
- Readdata: reflects the addressed register combinationally, with no wait states.
- Hex decode, active-high form, digits 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Per-digit lit pattern:
  - If BLANK=1, or (BLINK_EN=1 and BLINK_MASK[d]=1 and blink phase=1): pattern is 0.
  - Otherwise: raw segments if RAW=1, else hex decode of the nibble.
  - out_port = pattern, inverted when ACTIVE_LOW=1.
- out_port is registered. A write at edge N is visible on out_port after edge N+1 (latency 1 cycle from register update).
- Blink timer:
  - If BLINK_PERIOD=0, the counter holds 0 and phase holds 0 (blink never blanks).
  - Otherwise the counter decrements each cycle. On the cycle where counter=0, it reloads BLINK_PERIOD and phase toggles.
  - Phase therefore toggles every BLINK_PERIOD+1 cycles.
  - Any write to BLINK_PERIOD loads the counter with the new value and clears phase in that same edge.
  - A write that coincides with the counter reaching 0: the write wins and phase does not toggle.
- BLINK_EN=0 does not stop the timer; it only masks the blanking effect.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). On the first edge after release, out_port shows hex "0" on all digits.
- No back-pressure and no side effects on read.

Test Plan:
- Reset then release, NUM_DIGITS=4, ACTIVE_LOW=1 -> out_port = 28'hFFFFFFF while reset is high. One edge after release, each digit = 7'h40 ("0").
- Write DATA=32'h0000_A381 -> readdata at offset 0 = 32'h0000A381. One edge later, digits 0..3 = 7'h79, 7'h00, 7'h30, 7'h08.
- Write RAW_LO=32'h7F00_5500, then CTRL=1 -> digit0=7'h7F, digit1=7'h2A, digit2=7'h7F, digit3=7'h00 (raw, inverted). Write CTRL=3 -> all digits 7'h7F.
- BLINK_PERIOD=3, BLINK_MASK=4'b0010, CTRL=4 -> digit1 alternates blank/lit, toggling every 4 cycles. Other digits stay steady. Rewrite BLINK_PERIOD mid-count -> phase cleared, count restarts.
- BLINK_PERIOD=0 with BLINK_EN=1 -> no digit ever blanks over 100 cycles. Read offsets 6 and 7 -> 0.
- Assert reset mid-blink with CTRL=4 -> out_port all-off immediately. After release, all registers read 0 and blinking has stopped.

Source files
------------

// File: rtl/sevseg_ctrl.sv
// Avalon-MM seven-segment display controller: one register file drives NUM_DIGITS digits
// with hex or raw segment data, global blanking and a programmable per-digit blink.
module sevseg_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int BLINK_W    = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_RAW_LO = 3'd4;
    localparam logic [2:0] ADDR_RAW_HI = 3'd5;
    localparam int         SEG_W       = 7 * NUM_DIGITS;
    localparam logic [SEG_W-1:0] SEG_OFF = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic                    wr_s;
    logic                    period_wr_s;
    logic                    unused_s;
    logic [4*NUM_DIGITS-1:0] data_r;
    logic [2:0]              ctrl_r;
    logic [NUM_DIGITS-1:0]   mask_r;
    logic [BLINK_W-1:0]      period_r;
    logic [BLINK_W-1:0]      cnt_r;
    logic                    phase_r;
    logic [6:0]              raw_r [NUM_DIGITS];
    logic [6:0]              raw_all_s [8];
    logic [31:0]             readdata_s;
    logic [SEG_W-1:0]        seg_lit_s;
    logic [SEG_W-1:0]        seg_next_s;
    logic [SEG_W-1:0]        out_r;

    assign wr_s        = chipselect & ~write_n;
    assign period_wr_s = wr_s && (address == ADDR_PERIOD);
    // Field bits that are never stored still count as consumed inputs
    assign unused_s    = ^writedata;

    // Register file capture on writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r   <= {(4*NUM_DIGITS){1'b0}};
            ctrl_r   <= 3'b000;
            mask_r   <= {NUM_DIGITS{1'b0}};
            period_r <= {BLINK_W{1'b0}};
            for (int d = 0; d < NUM_DIGITS; d++) begin
                raw_r[d] <= 7'h00;
            end
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:   data_r   <= writedata[4*NUM_DIGITS-1:0];
                ADDR_CTRL:   ctrl_r   <= writedata[2:0];
                ADDR_MASK:   mask_r   <= writedata[NUM_DIGITS-1:0];
                ADDR_PERIOD: period_r <= writedata[BLINK_W-1:0];
                default: begin
                end
            endcase
            // Digits 0-3 live in RAW_LO, 4-7 in RAW_HI, one byte lane each
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (address == ((d < 4) ? ADDR_RAW_LO : ADDR_RAW_HI)) begin
                    raw_r[d] <= writedata[8*(d%4) +: 7];
                end
            end
        end
    end

    // Blink down-counter and phase; a period write restarts the count and wins over reload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {BLINK_W{1'b0}};
            phase_r <= 1'b0;
        end else if (period_wr_s) begin
            cnt_r   <= writedata[BLINK_W-1:0];
            phase_r <= 1'b0;
        end else if (period_r == {BLINK_W{1'b0}}) begin
            cnt_r   <= {BLINK_W{1'b0}};
            phase_r <= 1'b0;
        end else if (cnt_r == {BLINK_W{1'b0}}) begin
            cnt_r   <= period_r;
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r - {{(BLINK_W-1){1'b0}}, 1'b1};
        end
    end

    // Zero-extend stored raw fields to the full eight-digit map for readback
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            raw_all_s[k] = 7'h00;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            raw_all_s[d] = raw_r[d];
        end
    end

    // Combinational readback of the addressed register
    always_comb begin
        readdata_s = 32'h0000_0000;
        case (address)
            ADDR_DATA:   readdata_s[4*NUM_DIGITS-1:0] = data_r;
            ADDR_CTRL:   readdata_s[2:0]              = ctrl_r;
            ADDR_MASK:   readdata_s[NUM_DIGITS-1:0]   = mask_r;
            ADDR_PERIOD: readdata_s[BLINK_W-1:0]      = period_r;
            ADDR_RAW_LO: readdata_s = {1'b0, raw_all_s[3], 1'b0, raw_all_s[2],
                                       1'b0, raw_all_s[1], 1'b0, raw_all_s[0]};
            ADDR_RAW_HI: readdata_s = {1'b0, raw_all_s[7], 1'b0, raw_all_s[6],
                                       1'b0, raw_all_s[5], 1'b0, raw_all_s[4]};
            default:     readdata_s = 32'h0000_0000;
        endcase
    end

    assign readdata = readdata_s;

    // Per-digit lit pattern: blanking first, then raw or hex source
    always_comb begin
        seg_lit_s = {SEG_W{1'b0}};
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (ctrl_r[1] || (ctrl_r[2] && mask_r[d] && phase_r)) begin
                seg_lit_s[7*d +: 7] = 7'h00;
            end else if (ctrl_r[0]) begin
                seg_lit_s[7*d +: 7] = raw_r[d];
            end else begin
                seg_lit_s[7*d +: 7] = hex_to_seg(data_r[4*d +: 4]);
            end
        end
        seg_next_s = ACTIVE_LOW ? ~seg_lit_s : seg_lit_s;
    end

    // Registered segment outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= SEG_OFF;
        end else begin
            out_r <= seg_next_s;
        end
    end

    assign out_port = out_r;

endmodule

// File: tb/tb_sevseg_ctrl.sv
// Randomised self-checking bench for sevseg_ctrl against a cycle-count based reference model.
module tb_sevseg_ctrl;

    localparam int ND = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [27:0] out_port;

    int errors = 0;
    int checks = 0;

    sevseg_ctrl #(.NUM_DIGITS(ND), .ACTIVE_LOW(1'b1), .BLINK_W(26)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: registers as stored values, blink phase derived from edges since period write
    int unsigned m_data, m_ctrl, m_mask, m_period, m_rawlo, m_rawhi, m_k;
    logic [27:0] exp_out = 28'hFFFFFFF;

    function automatic logic [27:0] model_pattern();
        logic [27:0] r;
        logic [6:0]  s;
        bit          ph;
        int unsigned src;
        r  = 28'h0;
        ph = (m_period != 0) && (((m_k / (m_period + 1)) % 2) == 1);
        for (int d = 0; d < ND; d++) begin
            if ((m_ctrl & 2) != 0 || ((m_ctrl & 4) != 0 && ((m_mask >> d) & 1) != 0 && ph))
                s = 7'h00;
            else if ((m_ctrl & 1) != 0) begin
                src = (d < 4) ? (m_rawlo >> (8*d)) : (m_rawhi >> (8*(d-4)));
                s = src[6:0];
            end else
                s = hex_tab[4'((m_data >> (4*d)) & 15)];
            r[7*d +: 7] = ~s;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_data;
            3'd1: return m_ctrl;
            3'd2: return m_mask;
            3'd3: return m_period;
            3'd4: return m_rawlo;
            3'd5: return m_rawhi;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= 0; m_ctrl <= 0; m_mask <= 0; m_period <= 0;
            m_rawlo <= 0; m_rawhi <= 0; m_k <= 0;
            exp_out <= 28'hFFFFFFF;
        end else begin
            exp_out <= model_pattern();
            m_k <= m_k + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data  <= writedata & 32'h0000FFFF;
                    3'd1: m_ctrl  <= writedata & 32'h7;
                    3'd2: m_mask  <= writedata & 32'hF;
                    3'd3: begin m_period <= writedata & 32'h03FFFFFF; m_k <= 0; end
                    3'd4: m_rawlo <= writedata & 32'h7F7F7F7F;
                    default: ;
                endcase
            end
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic set_addr(input logic [2:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_port !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL reset_off: got %h want %h", out_port, 28'hFFFFFFF);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_port !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", out_port, 28'hFFFFFFF);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_port[7*d +: 7] !== 7'h40) begin
                errors++;
                $display("FAIL reset_digit%0d: got %h want %h", d, out_port[7*d +: 7], 7'h40);
            end
        end
    endtask

    task automatic test_hex();
        logic [6:0] want [4] = '{7'h79, 7'h00, 7'h30, 7'h08};
        do_write(3'd0, 32'h0000A381);
        set_addr(3'd0);
        checks++;
        if (readdata !== 32'h0000A381) begin
            errors++;
            $display("FAIL data_read: got %h want %h", readdata, 32'h0000A381);
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_port[7*d +: 7] !== want[d]) begin
                errors++;
                $display("FAIL hex_digit%0d: got %h want %h", d, out_port[7*d +: 7], want[d]);
            end
        end
        repeat (16) begin
            do_write(3'd0, $urandom);
            set_addr(3'd0);
            checks++;
            if (readdata !== model_read(3'd0)) begin
                errors++;
                $display("FAIL hex_rand_read: got %h want %h", readdata, model_read(3'd0));
            end
            @(negedge clk);
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL hex_rand_out: got %h want %h", out_port, exp_out);
            end
        end
    endtask

    task automatic test_raw();
        logic [6:0] want [4] = '{7'h7F, 7'h2A, 7'h7F, 7'h00};
        do_write(3'd4, 32'h7F005500);
        do_write(3'd1, 32'h1);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_port[7*d +: 7] !== want[d]) begin
                errors++;
                $display("FAIL raw_digit%0d: got %h want %h", d, out_port[7*d +: 7], want[d]);
            end
        end
        do_write(3'd1, 32'h3);
        @(negedge clk);
        checks++;
        if (out_port !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL blank_all: got %h want %h", out_port, 28'hFFFFFFF);
        end
        repeat (12) begin
            do_write(3'd4, $urandom);
            do_write(3'd5, $urandom);
            do_write(3'd1, $urandom_range(0, 1));
            for (int a = 0; a < 8; a++) begin
                set_addr(3'(a));
                checks++;
                if (readdata !== model_read(3'(a))) begin
                    errors++;
                    $display("FAIL raw_read%0d: got %h want %h", a, readdata, model_read(3'(a)));
                end
            end
            @(negedge clk);
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL raw_rand_out: got %h want %h", out_port, exp_out);
            end
        end
    endtask

    task automatic test_blink();
        logic [6:0] prev1, prev0;
        int tog1, tog0;
        do_write(3'd0, 32'h00001234);
        do_write(3'd3, 32'd3);
        do_write(3'd2, 32'h2);
        do_write(3'd1, 32'h4);
        @(negedge clk);
        prev1 = out_port[13:7]; prev0 = out_port[6:0];
        tog1 = 0; tog0 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_port[13:7] !== prev1) tog1++;
            if (out_port[6:0] !== prev0) tog0++;
            prev1 = out_port[13:7]; prev0 = out_port[6:0];
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL blink_out: got %h want %h", out_port, exp_out);
            end
        end
        checks++;
        if (tog1 != 4) begin
            errors++;
            $display("FAIL blink_toggles: got %0d want %0d", tog1, 4);
        end
        checks++;
        if (tog0 != 0) begin
            errors++;
            $display("FAIL blink_steady: got %0d want %0d", tog0, 0);
        end
        repeat (2) @(negedge clk);
        do_write(3'd3, 32'd5);
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL blink_rewrite: got %h want %h", out_port, exp_out);
            end
        end
        repeat (6) begin
            do_write(3'd3, $urandom_range(1, 6));
            do_write(3'd2, $urandom & 32'hF);
            do_write(3'd1, 32'h4 | $urandom_range(0, 1));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_write(3'd3, $urandom_range(1, 6));
            repeat (25) begin
                @(negedge clk);
                checks++;
                if (out_port !== exp_out) begin
                    errors++;
                    $display("FAIL blink_rand: got %h want %h", out_port, exp_out);
                end
            end
        end
    endtask

    task automatic test_period_zero();
        int blanks;
        do_write(3'd3, 32'd0);
        do_write(3'd0, 32'h0000A381);
        do_write(3'd2, 32'hF);
        do_write(3'd1, 32'h4);
        blanks = 0;
        repeat (100) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) if (out_port[7*d +: 7] === 7'h7F) blanks++;
            checks++;
            if (out_port !== exp_out) begin
                errors++;
                $display("FAIL pzero_out: got %h want %h", out_port, exp_out);
            end
        end
        checks++;
        if (blanks != 0) begin
            errors++;
            $display("FAIL pzero_blanks: got %0d want %0d", blanks, 0);
        end
        do_write(3'd6, 32'hFFFFFFFF);
        do_write(3'd7, 32'hFFFFFFFF);
        for (int a = 0; a < 8; a++) begin
            set_addr(3'(a));
            checks++;
            if (readdata !== model_read(3'(a))) begin
                errors++;
                $display("FAIL pzero_read%0d: got %h want %h", a, readdata, model_read(3'(a)));
            end
        end
        set_addr(3'd6);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL read_off6: got %h want %h", readdata, 32'h0);
        end
        set_addr(3'd7);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL read_off7: got %h want %h", readdata, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        do_write(3'd3, 32'd3);
        do_write(3'd2, 32'hF);
        do_write(3'd1, 32'h4);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_port !== 28'hFFFFFFF) begin
            errors++;
            $display("FAIL midreset_off: got %h want %h", out_port, 28'hFFFFFFF);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            set_addr(3'(a));
            checks++;
            if (readdata !== 32'h0) begin
                errors++;
                $display("FAIL midreset_read%0d: got %h want %h", a, readdata, 32'h0);
            end
        end
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (out_port !== 28'h8102040) begin
                errors++;
                $display("FAIL midreset_steady: got %h want %h", out_port, 28'h8102040);
            end
        end
    endtask

    initial begin
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        #1 reset = 1'b1;
        test_reset();
        test_hex();
        test_raw();
        test_blink();
        test_period_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
